// File: rtl/ram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants and types for the RAM-backed FIFO controller.
//   DEF_*        : default parameter values used by ram_fifo_ctrl and
//                  ram_fifo_out_stage
//   out_state_e  : output-stage FSM state (S_EMPTY / S_VALID)
// Build option (consumed by ram_fifo_ctrl): RAM_FIFO_CTRL_LEVEL_EN
// -----------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32'd32;
  localparam int unsigned DEF_ADDR_WIDTH   = 32'd16;
  localparam int unsigned DEF_DEPTH        = 32'd16;
  localparam int unsigned DEF_AFULL_THRESH = 32'd12;

  // Output register either holds a word for downstream or is empty.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } out_state_e;

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_out_stage.sv
// -----------------------------------------------------------------------------
// ram_fifo_out_stage
// Output register and two-state FSM of the RAM FIFO. The controller decides
// when a word is loaded from the RAM read port; this stage captures it and
// presents it to downstream with a valid/ready handshake.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : synchronous clear (empties the stage)
//   load_i            : capture load_data_i this edge
//   out_ready_i       : downstream accepts the presented word
//   load_data_i       : word read from the RAM
//   state_o           : current FSM state (used by the controller's load decode)
//   out_valid_o       : registered valid
//   out_data_o        : registered data
// -----------------------------------------------------------------------------
module ram_fifo_out_stage
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic                  out_ready_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output out_state_e            state_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  out_state_e            state_q;
  out_state_e            state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Next-state and next-data decode; flush wins over load, load wins over drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      data_d  = {DATA_WIDTH{1'b0}};
    end else if (load_i) begin
      state_d = S_VALID;
      data_d  = load_data_i;
    end else begin
      // No load this cycle means the RAM is empty (or we are holding).
      case (state_q)
        S_VALID: begin
          if (out_ready_i) begin
            state_d = S_EMPTY;
          end else begin
            state_d = S_VALID;
          end
        end
        S_EMPTY: state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Outputs are taken straight from the registers.
  always_comb begin
    state_o     = state_q;
    out_valid_o = (state_q == S_VALID);
    out_data_o  = data_q;
  end

endmodule : ram_fifo_out_stage

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
// FIFO controller over an external single-clock RAM with combinational read.
// Words are written into the RAM at wr_ptr, read out at rd_ptr and moved into
// a registered output stage (ram_fifo_out_stage), so the FIFO holds up to
// DEPTH words in RAM plus one in the output register.
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   flush_i                       : synchronous clear, beats push and load
//   in_valid_i/in_ready_o/in_data_i    : upstream push interface
//   out_valid_o/out_ready_i/out_data_o : downstream pop interface
//   ram_wren_o/ram_wr_add_o/ram_wr_data_o : RAM write port
//   ram_rd_add_o/ram_rd_data_i    : RAM read port (read data same cycle)
// Build option RAM_FIFO_CTRL_LEVEL_EN adds:
//   level_o       : words held (RAM count + output register)
//   almost_full_o : level_o >= AFULL_THRESH
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  ram_wren_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_add_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_add_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o
`endif
);

  // One extra bit so the count can reach DEPTH == 2**ADDR_WIDTH.
  localparam int unsigned          CNT_W    = ADDR_WIDTH + 32'd1;
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 32'd1);

  // Reject parameter sets the pointer/count widths cannot represent.
  if ((DEPTH < 32'd2) || (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) ||
      (AFULL_THRESH > (DEPTH + 32'd1))) begin : g_param_check
    $error("ram_fifo_ctrl: illegal DEPTH/ADDR_WIDTH/AFULL_THRESH combination");
  end

  // Pointer increment with wrap at DEPTH-1; DEPTH may be any value, not only 2**n.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return ptr + PTR_ONE;
    end
  endfunction

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  full_s;
  logic                  push_s;
  logic                  load_s;
  out_state_e            out_state_s;

  // Handshake decode. Readiness depends only on the count register, so a pop
  // in the same cycle never opens room for a push into a full RAM.
  always_comb begin
    full_s     = (count_q == CNT_FULL);
    in_ready_o = !full_s && !rst_i;
    push_s     = in_valid_i && in_ready_o && !flush_i;
    load_s     = (count_q != CNT_ZERO) &&
                 ((out_state_s == S_EMPTY) || out_ready_i) && !flush_i;
  end

  // RAM port drive: write goes straight through on a push, read address is rd_ptr.
  always_comb begin
    ram_wren_o    = push_s;
    ram_wr_add_o  = wr_ptr_q;
    ram_wr_data_o = in_data_i;
    ram_rd_add_o  = rd_ptr_q;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, load_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ram_fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .load_i      (load_s),
    .out_ready_i (out_ready_i),
    .load_data_i (ram_rd_data_i),
    .state_o     (out_state_s),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o)
  );

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  // Level decoded from registered count and output-stage state only.
  always_comb begin
    level_o       = count_q + {{ADDR_WIDTH{1'b0}}, out_valid_o};
    almost_full_o = (level_o >= CNT_W'(AFULL_THRESH));
  end
`endif

endmodule : ram_fifo_ctrl

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 16, RAM address width; DEPTH, default 16, number of RAM entries used (2..2**ADDR_WIDTH); AFULL_THRESH, default 12, almost-full level.
REQ-002 Ports SHALL be as follows; the block has one clock, and reset is synchronous and active-high.
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous clear
- in_valid_i  in  1  upstream word valid
- in_ready_o  out  1  upstream may push
- in_data_i  in  DATA_WIDTH  upstream word
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_WIDTH  output word
- ram_wren_o  out  1  RAM write enable
- ram_wr_add_o  out  ADDR_WIDTH  RAM write address
- ram_wr_data_o  out  DATA_WIDTH  RAM write data
- ram_rd_add_o  out  ADDR_WIDTH  RAM read address
- ram_rd_data_i  in  DATA_WIDTH  RAM read data (combinational read, same clock)

Function
REQ-003 The block SHALL run a FIFO over an external single-clock RAM, with write pointer wr_ptr, read pointer rd_ptr and RAM occupancy count (0..DEPTH).
REQ-004 in_ready_o SHALL be (count != DEPTH) && !rst_i, decoded from registers only.
REQ-005 A push SHALL occur when in_valid_i && in_ready_o && !flush_i.
- Push drives ram_wren_o=1, ram_wr_add_o=wr_ptr, ram_wr_data_o=in_data_i combinationally.
- On a push, wr_ptr advances at the clock edge.
REQ-006 ram_rd_add_o SHALL equal rd_ptr at all times.
REQ-007 The output-stage FSM SHALL have two states: S_EMPTY (out_valid_o=0) and S_VALID (out_valid_o=1).
REQ-008 A load SHALL occur when count>0 and (state==S_EMPTY or out_ready_i==1).
- On a load, out_data_o <= ram_rd_data_i and rd_ptr advances.
- The FSM enters or stays in S_VALID.
REQ-009 In S_VALID with out_ready_i=1 and count==0, the FSM SHALL go to S_EMPTY.
REQ-010 In S_VALID with out_ready_i=0, out_data_o SHALL hold.
REQ-011 Pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-012 count SHALL update as +1 on push only, -1 on load only, and unchanged on both or neither.
REQ-013 First-word latency SHALL be 2 edges: push accepted at edge E0, out_valid_o=1 after edge E1.
REQ-014 There SHALL be no combinational path from in_data_i to out_data_o and no push when full, even if a pop happens the same cycle.
REQ-015 flush_i SHALL take priority over push and load.
- Next edge: pointers=0, count=0, state=S_EMPTY.
- The current cycle's write is suppressed.
REQ-016 Stale RAM contents SHALL never be presented after flush or reset.

Reset
REQ-017 On rst_i=1 at a clock edge:
- wr_ptr, rd_ptr and count SHALL be 0, and state SHALL be S_EMPTY.
- out_valid_o=0 and out_data_o=0.
REQ-018 While rst_i=1, in_ready_o=0 and ram_wren_o=0.
REQ-019 Reset mid-transfer SHALL discard all queued words; RAM contents are not cleared.

Configuration
REQ-020 Macro RAM_FIFO_CTRL_LEVEL_EN defined SHALL add outputs level_o [ADDR_WIDTH:0] and almost_full_o.
- level_o = count + out_valid_o, registered-derived, reset 0.
- almost_full_o = (level_o >= AFULL_THRESH).
REQ-021 Without RAM_FIFO_CTRL_LEVEL_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-022 Package ram_fifo_pkg SHALL hold the default width/depth constants and the output-state enum (S_EMPTY, S_VALID).
REQ-023 The output register and FSM SHALL be sub-module ram_fifo_out_stage; pointer/count logic stays in the top.

Verification
REQ-024 Reset, then push 0xA5A5_0001: ram_wren_o=1 with address 0 at E0; out_valid_o=1 with out_data_o=0xA5A5_0001 after E1.
REQ-025 DEPTH=16, out_ready_i=0, push 18 words:
- in_ready_o drops after 16 RAM words plus 1 held in the output stage.
- The first word is held stable.
REQ-026 DEPTH=5, stream 12 words with out_ready_i=1:
- Addresses wrap 4 to 0.
- Output order matches input order with no gaps after fill.
REQ-027 Full, then assert in_valid_i and out_ready_i together: no write in that cycle; count goes 5 to 4.
REQ-028 flush_i with 3 queued words and a simultaneous push:
- ram_wren_o=0 in that cycle.
- Next cycle out_valid_o=0, count=0, and the next push lands at address 0.
REQ-029 With the macro on and AFULL_THRESH=12, push 12 words: almost_full_o=1 and level_o=12.
